// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU
// Sign handling wraps an unsigned core; special cases bypass the iteration.
module div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUNNING, FINISH} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  count;
  logic [N-1:0]   q_reg, r_reg, d_reg;
  logic           neg_q, neg_r, special;

  logic           div_zero, overflow;
  logic [N-1:0]   abs_a, abs_b;
  logic [N:0]     r_shift, diff;
  logic           fits;

  assign div_zero = (divisor == '0);
  assign overflow = is_signed && (dividend == MIN_VAL) && (divisor == '1);
  assign abs_a    = (is_signed && dividend[N-1]) ? -dividend : dividend;
  assign abs_b    = (is_signed && divisor[N-1])  ? -divisor  : divisor;

  // Partial remainder stays below the divisor, so the borrow bit alone decides the step.
  assign r_shift  = {r_reg, q_reg[N-1]};
  assign diff     = r_shift - {1'b0, d_reg};
  assign fits     = ~diff[N];

  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (div_zero || overflow) ? FINISH : RUNNING;
      end
      RUNNING: begin
        if (count == CW'(N-1)) state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_q <= is_signed & (dividend[N-1] ^ divisor[N-1]) & ~div_zero;
            neg_r <= is_signed & dividend[N-1];
            count <= '0;
            d_reg <= abs_b;
            if (div_zero) begin
              special <= 1'b1;
              q_reg   <= '1;
              r_reg   <= dividend;
            end else if (overflow) begin
              special <= 1'b1;
              q_reg   <= MIN_VAL;
              r_reg   <= '0;
            end else begin
              special <= 1'b0;
              q_reg   <= abs_a;
              r_reg   <= '0;
            end
          end
        end
        RUNNING: begin
          q_reg <= {q_reg[N-2:0], fits};
          r_reg <= fits ? diff[N-1:0] : r_shift[N-1:0];
          count <= count + 1'b1;
        end
        FINISH: begin
          if (special) begin
            quotient  <= q_reg;
            remainder <= r_reg;
          end else begin
            quotient  <= neg_q ? -q_reg : q_reg;
            remainder <= neg_r ? -r_reg : r_reg;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
